// File: rtl/mixing_player_pkg.sv
// Shared types and helpers for the voice mixer.
package mixing_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    MIX,
    SCALE,
    HOLD
  } state_t;

  // Accumulator wide enough to sum num_voices full-scale samples without overflow.
  function automatic int acc_width(input int num_voices, input int sample_w);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/mixing_player_beat_generator.sv
// Counts request pulses and emits a one-cycle beat each time the count wraps.
module beat_generator #(
  parameter int WIDTH = 10,
  parameter int STOP  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic beat
);

  logic [WIDTH-1:0] count;

  // Wrap at STOP-1; beat rises on the same edge the counter returns to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      beat  <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (en) begin
        if (count == WIDTH'(STOP - 1)) begin
          count <= '0;
          beat  <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mixing_player.sv
// Frame-synchronous voice mixer: request, collect, sum, scale/saturate, hold.
module mixing_player
  import mixing_player_pkg::*;
#(
  parameter int NUM_VOICES      = 4,
  parameter int SAMPLE_W        = 16,
  parameter int BEAT_COUNT      = 1000,
  parameter int COLLECT_TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           new_frame,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  input  logic [2:0]                     volume,
  output logic                           generate_next_sample,
  output logic                           beat,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic                           mix_done,
  output logic                           overrun,
  output logic                           clipped
);

  localparam int AW = acc_width(NUM_VOICES, SAMPLE_W);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW = $clog2(COLLECT_TIMEOUT + 1);
  localparam int BW = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  state_t state, state_nxt;

  logic [NUM_VOICES-1:0]                captured, cap_set;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  smp;
  logic [TW-1:0]                        tmo;
  logic [IW-1:0]                        idx;
  logic signed [AW-1:0]                 acc, acc_sh;
  logic signed [SAMPLE_W-1:0]           held, cur, sat_val;
  logic                                 all_in, busy, sat_hi, sat_lo;

  // Only the first ready pulse per voice inside COLLECT is taken.
  assign cap_set = (state == COLLECT) ? (voice_ready & ~captured) : '0;
  assign all_in  = ((captured | cap_set) & voice_enable) == voice_enable;
  assign busy    = state inside {COLLECT, MIX, SCALE};

  // Uncaptured or muted voices contribute zero.
  assign cur     = (captured[idx] && voice_enable[idx]) ? smp[idx] : '0;
  assign acc_sh  = acc >>> volume;
  assign sat_hi  = acc_sh > SMAX;
  assign sat_lo  = acc_sh < SMIN;
  assign sat_val = sat_hi ? SMAX[SAMPLE_W-1:0] :
                   sat_lo ? SMIN[SAMPLE_W-1:0] : acc_sh[SAMPLE_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a frame arriving while busy aborts the mix.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: if (new_frame) state_nxt = play ? COLLECT : IDLE;
      COLLECT: begin
        if (new_frame) state_nxt = IDLE;
        else if (all_in || tmo == TW'(COLLECT_TIMEOUT - 1)) state_nxt = MIX;
      end
      MIX: begin
        if (new_frame) state_nxt = IDLE;
        else if (idx == IW'(NUM_VOICES - 1)) state_nxt = SCALE;
      end
      SCALE:   state_nxt = new_frame ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Voice capture, collect timeout and serial accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      captured <= '0;
      smp      <= '0;
      tmo      <= '0;
      idx      <= '0;
      acc      <= '0;
    end else begin
      if (state_nxt == COLLECT && state != COLLECT) begin
        captured <= '0;
        tmo      <= '0;
      end else if (state == COLLECT) begin
        captured <= captured | cap_set;
        tmo      <= tmo + TW'(1);
        for (int i = 0; i < NUM_VOICES; i++)
          if (cap_set[i]) smp[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
      end
      if (state != MIX) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + IW'(1);
        acc <= acc + AW'(cur);
      end
    end
  end

  // Frame output, request pulse, held sample and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held                 <= '0;
      sample_out           <= '0;
      generate_next_sample <= 1'b0;
      mix_done             <= 1'b0;
      overrun              <= 1'b0;
      clipped              <= 1'b0;
    end else begin
      generate_next_sample <= new_frame && play && (state == IDLE || state == HOLD);
      mix_done             <= 1'b0;
      if (new_frame) begin
        sample_out <= play ? held : '0;
        if (busy) overrun <= 1'b1;
      end else if (state == SCALE) begin
        held     <= sat_val;
        mix_done <= 1'b1;
        if (sat_hi || sat_lo) clipped <= 1'b1;
      end
    end
  end

  beat_generator #(
    .WIDTH (BW),
    .STOP  (BEAT_COUNT)
  ) u_beat (
    .clk   (clk),
    .reset (reset),
    .en    (generate_next_sample),
    .beat  (beat)
  );

endmodule

// File: doc/mixing_player.md
MIXING_PLAYER -- requirements
Module: mixing_player

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: number of voice sample inputs mixed (1..16).
REQ-002 SHALL have parameter SAMPLE_W, default 16: signed two's-complement sample width.
REQ-003 SHALL have parameter BEAT_COUNT, default 1000: generate_next_sample pulses per beat.
REQ-004 SHALL have parameter COLLECT_TIMEOUT, default 256: maximum cycles spent waiting for voices.
REQ-005 SHALL have port clk, input, 1: the single system clock; all state is on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port play, input, 1: level; 1 = mixing and beats run.
REQ-008 SHALL have port new_frame, input, 1: one-cycle codec frame pulse (48 kHz).
REQ-009 SHALL have port voice_sample, input, NUM_VOICES*SAMPLE_W: packed voice samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
REQ-010 SHALL have port voice_ready, input, NUM_VOICES: voice i sample is valid this cycle.
REQ-011 SHALL have port voice_enable, input, NUM_VOICES: mute mask; 0 excludes the voice from the sum.
REQ-012 SHALL have port volume, input, 3: attenuation, applied as an arithmetic right shift of 0..7.
REQ-013 SHALL have port generate_next_sample, output, 1: one-cycle request to the voices.
REQ-014 SHALL have port beat, output, 1: one-cycle beat pulse.
REQ-015 SHALL have port sample_out, output, SAMPLE_W: frame-synchronous output sample.
REQ-016 SHALL have port mix_done, output, 1: one-cycle pulse when a new mixed sample is held.
REQ-017 SHALL have port overrun, output, 1: sticky flag; a frame arrived before mixing finished.
REQ-018 SHALL have port clipped, output, 1: sticky flag; saturation occurred.

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, MIX, SCALE, HOLD.
REQ-020 On new_frame, sample_out SHALL load the held register on the same edge, giving one cycle of latency from the frame pulse.
REQ-021 generate_next_sample SHALL pulse the cycle after new_frame only when play=1 and the FSM is in IDLE or HOLD; the FSM then enters COLLECT with all captured-ready bits cleared.
REQ-022 In COLLECT, each voice SHALL be captured on the first cycle its voice_ready=1; later ready pulses in the same frame SHALL be ignored.
REQ-023 COLLECT SHALL exit to MIX when every enabled voice is captured, or after COLLECT_TIMEOUT cycles; uncaptured voices contribute 0.
REQ-024 If voice_enable is all zero, COLLECT SHALL exit to MIX on the next cycle and the mix result SHALL be 0.
REQ-025 MIX SHALL add one voice per cycle (NUM_VOICES cycles) into a signed accumulator of width SAMPLE_W+clog2(NUM_VOICES), with no overflow possible.
REQ-026 SCALE SHALL take one cycle: shift the accumulator right arithmetically by volume, then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-027 SCALE SHALL set clipped whenever saturation occurs.
REQ-028 SCALE SHALL write the held register, pulse mix_done, and enter HOLD.
REQ-029 A new_frame in COLLECT, MIX or SCALE SHALL set overrun and leave the held register unchanged, so sample_out repeats the previous value.
REQ-030 After such an overrun frame, the FSM SHALL abort to IDLE; no generate_next_sample is issued for that frame.
REQ-031 The beat counter SHALL count generate_next_sample pulses from 0 to BEAT_COUNT-1, pulse beat on the edge where it wraps to 0, and hold its value while play=0.
REQ-032 play falling SHALL take effect at the next frame: sample_out loads 0 on that new_frame and then on every new_frame while play=0.
REQ-033 play falling mid-mix SHALL let the current mix complete into the held register.
REQ-034 overrun and clipped SHALL clear only on reset.

Reset
REQ-035 Reset assertion SHALL asynchronously force IDLE, beat counter 0, held register 0, and sample_out 0.
REQ-036 Reset assertion SHALL asynchronously force generate_next_sample, beat, mix_done, overrun and clipped to 0.
REQ-037 Reset release SHALL wait for the next new_frame before any request is issued.

Structure
REQ-038 A shared package SHALL hold the FSM state enum and a clog2-based accumulator-width constant function.
REQ-039 The beat counter SHALL be the sub-module beat_generator, parameterised by WIDTH and STOP and enabled by generate_next_sample.

Verification
REQ-040 4 voices, all enabled, samples 1000/2000/3000/4000, volume=0, ready 3 cycles after request -> mix_done, then sample_out=10000 on the next new_frame.
REQ-041 4 voices each 30000, volume=0 -> sample_out=32767 and clipped=1; all -30000 -> -32768; volume=2 with 4 x 8000 -> 8000 and clipped=0.
REQ-042 Voice 2 never ready, COLLECT_TIMEOUT=16, others 100 -> sample_out=300 at the frame after timeout.
REQ-043 new_frame re-asserted 5 cycles after the request while still in COLLECT -> overrun=1, sample_out repeats the previous value, no request that frame.
REQ-044 BEAT_COUNT=10, play=1 for 25 frames -> beat pulses after requests 10 and 20; play=0 for 5 frames -> no beats, counter frozen at 5, sample_out=0.
REQ-045 Reset asserted mid-MIX -> all outputs 0 immediately; first request appears only after the first new_frame following release.
